// File: rtl/counter_pkg.sv
// Shared constants for the cascaded up/down counter: direction encoding,
// terminal-mode selection and default digit width.
package counter_pkg;

   localparam logic DIR_UP     = 1'b1;
   localparam logic DIR_DOWN   = 1'b0;
   localparam int   MODE_WRAP  = 1;
   localparam int   MODE_STOP  = 0;
   localparam int   DEFAULT_DW = 4;

endpackage

// File: rtl/counter_digit.sv
// One digit of the cascade: purely combinational next-state with its own limit.
// step_out is the carry (up) or borrow (down) that moves the next digit.
module counter_digit
   import counter_pkg::*;
#(
   parameter int DW = DEFAULT_DW
) (
   input  logic [DW-1:0] d,
   input  logic [DW-1:0] limit_i,
   input  logic          step_in,
   input  logic          up,
   output logic [DW-1:0] d_next,
   output logic          step_out
);

   always_comb begin
      d_next   = d;
      step_out = 1'b0;
      if (step_in) begin
         if (up == DIR_UP) begin
            // Digits already beyond their limit wrap on the next up step.
            if (d >= limit_i) begin
               d_next   = '0;
               step_out = 1'b1;
            end else begin
               d_next = d + 1'b1;
            end
         end else begin
            if (d == '0) begin
               d_next   = limit_i;
               step_out = 1'b1;
            end else begin
               d_next = d - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cascade_updown_counter.sv
// Multi-digit cascaded up/down counter with per-digit limits, synchronous load,
// wrap-or-stop terminal behaviour and a registered terminal-count pulse.
module cascade_updown_counter
   import counter_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DW     = DEFAULT_DW,
   parameter int WRAP   = MODE_WRAP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 up,
   input  logic                 load,
   input  logic [DIGITS*DW-1:0] init_value,
   input  logic [DIGITS*DW-1:0] load_value,
   input  logic [DIGITS*DW-1:0] limit,
   output logic [DIGITS*DW-1:0] value,
   output logic                 tc,
   output logic                 done,
   output logic                 zero
);

   localparam int VW = DIGITS * DW;

   logic [VW-1:0]   value_q, value_d;
   logic            tc_q, tc_d;
   logic            done_q, done_d;
   logic [VW-1:0]   stepped;
   logic [DIGITS:0] step;
   logic            terminal;
   logic            lands;

   assign step[0] = en;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      counter_digit #(
         .DW(DW)
      ) u_digit (
         .d       (value_q[g*DW +: DW]),
         .limit_i (limit[g*DW +: DW]),
         .step_in (step[g]),
         .up      (up),
         .d_next  (stepped[g*DW +: DW]),
         .step_out(step[g+1])
      );
   end

   // The chain only starts from en, so a top-digit carry/borrow implies en.
   assign terminal = step[DIGITS];
   assign lands    = (up == DIR_UP) ? (stepped == limit) : (stepped == '0);

   always_comb begin
      value_d = value_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (load) begin
         value_d = load_value;
         done_d  = 1'b0;
      end else if (WRAP == MODE_WRAP) begin
         if (en) begin
            value_d = stepped;
            tc_d    = terminal;
         end
      end else if (en && !done_q) begin
         // Already sitting on terminal: flag it without moving the value.
         if (terminal) begin
            done_d = 1'b1;
            tc_d   = 1'b1;
         end else begin
            value_d = stepped;
            if (lands) begin
               done_d = 1'b1;
               tc_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= init_value;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign value = value_q;
   assign tc    = tc_q;
   assign done  = done_q;
   assign zero  = (value_q == '0);

endmodule

// File: tb/tb_cascade_updown_counter.sv
// Bench for cascade_updown_counter: a wrap-mode and a stop-mode instance share
// stimulus and are checked each cycle against a mixed-radix counting model.
module tb_cascade_updown_counter;

   localparam logic [15:0] INIT = 16'h0130;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        up = 1'b0;
   logic        load = 1'b0;
   logic [15:0] init_value = INIT;
   logic [15:0] load_value = '0;
   logic [15:0] limit = 16'h9959;

   logic [15:0] v0, v1;
   logic        tc0, tc1, dn0, dn1, z0, z1;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   cascade_updown_counter #(.DIGITS(4), .DW(4), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .init_value(init_value), .load_value(load_value), .limit(limit),
      .value(v0), .tc(tc0), .done(dn0), .zero(z0)
   );

   cascade_updown_counter #(.DIGITS(4), .DW(4), .WRAP(0)) u_stop (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .init_value(init_value), .load_value(load_value), .limit(limit),
      .value(v1), .tc(tc1), .done(dn1), .zero(z1)
   );

   // Mixed-radix step: returns {terminal, next}. Up: lowest digit below its
   // limit increments and everything under it clears. Down: lowest nonzero
   // digit decrements and everything under it refills to its limit.
   function automatic logic [16:0] model_step(input logic [15:0] v, input logic [15:0] lim,
                                              input logic dir_up);
      logic [3:0] d [4];
      logic [3:0] l [4];
      int k;
      logic [15:0] nv;
      k = -1;
      for (int i = 0; i < 4; i++) begin
         d[i] = v[i*4 +: 4];
         l[i] = lim[i*4 +: 4];
      end
      for (int i = 3; i >= 0; i--) begin
         if (dir_up ? (d[i] < l[i]) : (d[i] != 4'd0)) k = i;
      end
      for (int i = 0; i < 4; i++) begin
         if (k < 0 || i < k) d[i] = dir_up ? 4'd0 : l[i];
         else if (i == k) d[i] = dir_up ? d[i] + 4'd1 : d[i] - 4'd1;
      end
      for (int i = 0; i < 4; i++) nv[i*4 +: 4] = d[i];
      return {(k < 0), nv};
   endfunction

   logic [15:0] m_val0, m_val1;
   logic        m_tc0, m_tc1, m_done1;
   logic [16:0] r0, r1;

   assign r0 = model_step(m_val0, limit, up);
   assign r1 = model_step(m_val1, limit, up);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_val0 <= INIT; m_val1 <= INIT;
         m_tc0 <= 1'b0; m_tc1 <= 1'b0; m_done1 <= 1'b0;
      end else begin
         if (load) begin
            m_val0 <= load_value; m_tc0 <= 1'b0;
         end else if (en) begin
            m_val0 <= r0[15:0]; m_tc0 <= r0[16];
         end else begin
            m_tc0 <= 1'b0;
         end
         if (load) begin
            m_val1 <= load_value; m_tc1 <= 1'b0; m_done1 <= 1'b0;
         end else if (en && !m_done1) begin
            if (r1[16]) begin
               m_done1 <= 1'b1; m_tc1 <= 1'b1;
            end else begin
               m_val1 <= r1[15:0];
               if (up ? (r1[15:0] == limit) : (r1[15:0] == 16'h0000)) begin
                  m_done1 <= 1'b1; m_tc1 <= 1'b1;
               end else begin
                  m_tc1 <= 1'b0;
               end
            end
         end else begin
            m_tc1 <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("wrap_value", 32'(v0), 32'(m_val0));
         check("wrap_tc", 32'(tc0), 32'(m_tc0));
         check("wrap_done", 32'(dn0), 32'd0);
         check("wrap_zero", 32'(z0), 32'(m_val0 == 16'h0000));
         check("stop_value", 32'(v1), 32'(m_val1));
         check("stop_tc", 32'(tc1), 32'(m_tc1));
         check("stop_done", 32'(dn1), 32'(m_done1));
         check("stop_zero", 32'(z1), 32'(m_val1 == 16'h0000));
      end
   end

   task automatic cyc(input logic e, input logic u, input logic l, input logic [15:0] lv);
      en = e; up = u; load = l; load_value = lv;
      @(posedge clk);
      #1;
      en = 1'b0; load = 1'b0;
   endtask

   function automatic logic [15:0] rand_val(input logic [15:0] lim);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 0) r[i*4 +: 4] = 4'($urandom_range(0, 32'(lim[i*4 +: 4])));
         else r[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
      return r;
   endfunction

   initial begin
      #2 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_value", 32'(v0), 32'h0130);
      check("rst_tc", 32'(tc0), 32'd0);
      check("rst_done", 32'(dn1), 32'd0);
      rst = 1'b0;
      chk_on = 1'b1;

      // Step down from the reset value.
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("t1_value", 32'(v0), 32'h0129);
      check("t1_tc", 32'(tc0), 32'd0);
      check("t1_zero", 32'(z0), 32'd0);

      // Wrap at both ends.
      cyc(1'b0, 1'b0, 1'b1, 16'h0000);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("t2_down_value", 32'(v0), 32'h9959);
      check("t2_down_tc", 32'(tc0), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      check("t2_tc_pulse", 32'(tc0), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 16'h9959);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("t2_up_value", 32'(v0), 32'h0000);
      check("t2_up_tc", 32'(tc0), 32'd1);
      check("t2_up_zero", 32'(z0), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 16'h0059);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("t2_carry", 32'(v0), 32'h0100);

      // Stop mode.
      cyc(1'b0, 1'b0, 1'b1, 16'h0001);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("t3_value", 32'(v1), 32'h0000);
      check("t3_done", 32'(dn1), 32'd1);
      check("t3_tc", 32'(tc1), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("t3_hold_tc", 32'(tc1), 32'd0);
      check("t3_hold_value", 32'(v1), 32'h0000);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("t3_up_ignored", 32'(v1), 32'h0000);
      check("t3_up_done", 32'(dn1), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 16'h0100);
      check("t3_load_clr", 32'(dn1), 32'd0);
      check("t3_load_val", 32'(v1), 32'h0100);

      // Load beats enable.
      cyc(1'b1, 1'b1, 1'b1, 16'h0042);
      check("t4_value", 32'(v0), 32'h0042);
      check("t4_tc", 32'(tc0), 32'd0);

      // Out-of-range digits.
      cyc(1'b0, 1'b0, 1'b1, 16'h0070);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      check("t5_down", 32'(v0), 32'h0069);
      cyc(1'b0, 1'b0, 1'b1, 16'h0079);
      cyc(1'b1, 1'b1, 1'b0, 16'h0000);
      check("t5_up", 32'(v0), 32'h0100);

      // Asynchronous reset while counting.
      en = 1'b1; up = 1'b1;
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t6_async_value", 32'(v0), 32'h0130);
      check("t6_async_tc", 32'(tc0), 32'd0);
      check("t6_async_done", 32'(dn1), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check("t6_resume", 32'(v0), 32'h0131);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) limit = ($urandom_range(0, 1) == 0) ? 16'h9959 : 16'($urandom);
         en = ($urandom_range(0, 3) != 0);
         up = 1'($urandom_range(0, 1));
         load = ($urandom_range(0, 19) == 0);
         load_value = rand_val(limit);
         if (i % 500 == 250) begin
            #2 rst = 1'b1;
            #4 rst = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      en = 1'b0; load = 1'b0;
      @(posedge clk); #1;
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
